// File: rtl/fm_modulator_if.sv
// Sample-stream bundle for fm_modulator: audio samples in, interleaved I/Q samples out.
interface fm_modulator_if;
  logic [9:0] audio;
  logic       audio_valid;
  logic       audio_ready;
  logic [9:0] X;
  logic [2:0] channel;
  logic       x_valid;

  modport master (
    output audio, audio_valid,
    input  audio_ready, X, channel, x_valid
  );

  modport slave (
    input  audio, audio_valid,
    output audio_ready, X, channel, x_valid
  );
endinterface

// File: rtl/fm_modulator.sv
// FM modulator: phase accumulator driven by audio deviation, quarter-wave LUT emits I then Q.
// Optional pre-emphasis on the audio path is enabled by defining FM_MOD_PREEMPH_EN.
module fm_modulator #(
  parameter int                 PHASE_W     = 16,
  parameter logic [PHASE_W-1:0] INC_CARRIER = '0,
  parameter int                 DEV_SHIFT   = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  fm_modulator_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, OUT_I, OUT_Q} state_t;

  state_t              state_q, state_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic signed [9:0]   samp_q, samp_d;
  logic [9:0]          x_q, x_d;
  logic [2:0]          channel_q, channel_d;
  logic                x_valid_q, x_valid_d;

  logic                accept;
  logic signed [9:0]   a_in, y_in;
  logic [PHASE_W-1:0]  freq_word, phase_next;
  logic [7:0]          idx;
  logic signed [9:0]   cos_v, sin_v;

  // Quarter-wave magnitude, m in 0..64; entry 64 is the peak not held in the table.
  function automatic logic [8:0] qlut(input logic [6:0] m);
    logic [8:0] r;
    case (m[5:0])
      6'd0:  r = 9'd0;   6'd1:  r = 9'd13;  6'd2:  r = 9'd25;  6'd3:  r = 9'd38;
      6'd4:  r = 9'd50;  6'd5:  r = 9'd63;  6'd6:  r = 9'd75;  6'd7:  r = 9'd87;
      6'd8:  r = 9'd100; 6'd9:  r = 9'd112; 6'd10: r = 9'd124; 6'd11: r = 9'd136;
      6'd12: r = 9'd148; 6'd13: r = 9'd160; 6'd14: r = 9'd172; 6'd15: r = 9'd184;
      6'd16: r = 9'd196; 6'd17: r = 9'd207; 6'd18: r = 9'd218; 6'd19: r = 9'd230;
      6'd20: r = 9'd241; 6'd21: r = 9'd252; 6'd22: r = 9'd263; 6'd23: r = 9'd273;
      6'd24: r = 9'd284; 6'd25: r = 9'd294; 6'd26: r = 9'd304; 6'd27: r = 9'd314;
      6'd28: r = 9'd324; 6'd29: r = 9'd334; 6'd30: r = 9'd343; 6'd31: r = 9'd352;
      6'd32: r = 9'd361; 6'd33: r = 9'd370; 6'd34: r = 9'd379; 6'd35: r = 9'd387;
      6'd36: r = 9'd395; 6'd37: r = 9'd403; 6'd38: r = 9'd410; 6'd39: r = 9'd418;
      6'd40: r = 9'd425; 6'd41: r = 9'd432; 6'd42: r = 9'd438; 6'd43: r = 9'd445;
      6'd44: r = 9'd451; 6'd45: r = 9'd456; 6'd46: r = 9'd462; 6'd47: r = 9'd467;
      6'd48: r = 9'd472; 6'd49: r = 9'd477; 6'd50: r = 9'd481; 6'd51: r = 9'd485;
      6'd52: r = 9'd489; 6'd53: r = 9'd492; 6'd54: r = 9'd496; 6'd55: r = 9'd499;
      6'd56: r = 9'd501; 6'd57: r = 9'd503; 6'd58: r = 9'd505; 6'd59: r = 9'd507;
      6'd60: r = 9'd509; 6'd61: r = 9'd510; 6'd62: r = 9'd510; 6'd63: r = 9'd511;
      default: r = 9'd0;
    endcase
    if (m[6]) r = 9'd511;
    return r;
  endfunction

  function automatic logic signed [9:0] sine(input logic [7:0] k);
    logic [6:0] m;
    logic [8:0] mag;
    m   = k[6] ? (7'd64 - {1'b0, k[5:0]}) : {1'b0, k[5:0]};
    mag = qlut(m);
    return k[7] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  function automatic logic [9:0] to_offset(input logic signed [9:0] s);
    return {~s[9], s[8:0]};
  endfunction

  assign bus.audio_ready = en & (state_q == IDLE);
  assign accept          = bus.audio_valid & bus.audio_ready;
  assign a_in            = {~bus.audio[9], bus.audio[8:0]};

  assign freq_word  = INC_CARRIER + ({{(PHASE_W-10){samp_q[9]}}, samp_q} << DEV_SHIFT);
  assign phase_next = phase_q + freq_word;
  // The I sample is looked up from the phase being written, so it lands on entry to OUT_I.
  assign idx   = (state_q == CALC) ? phase_next[PHASE_W-1 -: 8] : phase_q[PHASE_W-1 -: 8];
  assign cos_v = sine(idx + 8'd64);
  assign sin_v = sine(idx);

`ifdef FM_MOD_PREEMPH_EN
  logic signed [9:0]  a_prev_q, a_prev_d;
  logic signed [11:0] a_ext, diff, y_wide;

  always_comb begin
    a_ext  = {{2{a_in[9]}}, a_in};
    diff   = a_ext - {{2{a_prev_q[9]}}, a_prev_q};
    y_wide = a_ext + (diff >>> 1);
    if (y_wide > 12'sd511)       y_in = 10'sd511;
    else if (y_wide < -12'sd511) y_in = -10'sd511;
    else                         y_in = y_wide[9:0];
    a_prev_d = accept ? a_in : a_prev_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn)   a_prev_q <= '0;
    else if (en) a_prev_q <= a_prev_d;
  end
`else
  assign y_in = a_in;
`endif

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    samp_d    = samp_q;
    x_d       = x_q;
    channel_d = channel_q;
    x_valid_d = x_valid_q;
    if (en) begin
      case (state_q)
        IDLE: if (accept) begin
          samp_d  = y_in;
          state_d = CALC;
        end
        CALC: begin
          phase_d   = phase_next;
          x_d       = to_offset(cos_v);
          channel_d = 3'b110;
          x_valid_d = 1'b1;
          state_d   = OUT_I;
        end
        OUT_I: begin
          x_d       = to_offset(sin_v);
          channel_d = 3'b100;
          x_valid_d = 1'b1;
          state_d   = OUT_Q;
        end
        default: begin
          channel_d = 3'b000;
          x_valid_d = 1'b0;
          state_d   = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      samp_q    <= '0;
      x_q       <= 10'd512;
      channel_q <= 3'b000;
      x_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      samp_q    <= samp_d;
      x_q       <= x_d;
      channel_q <= channel_d;
      x_valid_q <= x_valid_d;
    end
  end

  assign bus.X       = x_q;
  assign bus.channel = channel_q;
  assign bus.x_valid = x_valid_q & en;

endmodule

// File: tb/tb_fm_modulator.sv
// Directed self-checking bench for fm_modulator with hand-computed I/Q expectations.
module tb_fm_modulator;
  logic clk = 1'b0;
  logic rstn;
  logic en;
  int   check_count = 0;
  int   pass_count  = 0;

  fm_modulator_if bus();

  fm_modulator dut (
    .clk  (clk),
    .rstn (rstn),
    .en   (en),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn            = 1'b0;
    en              = 1'b1;
    bus.audio_valid = 1'b0;
    bus.audio       = 10'd512;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  // Offers one sample and follows it through CALC, OUT_I, OUT_Q back to IDLE.
  task automatic send_sample(input logic [9:0] s, output logic [9:0] xi,
                             output logic [9:0] xq, output logic ok);
    int waited = 0;
    ok = 1'b1;
    xi = '0;
    xq = '0;
    bus.audio       = s;
    bus.audio_valid = 1'b1;
    while (!bus.audio_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!bus.audio_ready) ok = 1'b0;
    tick();
    bus.audio_valid = 1'b0;
    if (bus.x_valid !== 1'b0) ok = 1'b0;
    tick();
    if (!(bus.x_valid === 1'b1 && bus.channel === 3'b110)) ok = 1'b0;
    xi = bus.X;
    tick();
    if (!(bus.x_valid === 1'b1 && bus.channel === 3'b100)) ok = 1'b0;
    xq = bus.X;
    tick();
    if (!(bus.x_valid === 1'b0 && bus.channel === 3'b000)) ok = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] xi, xq;
    logic ok;
    do_reset();
    send_sample(10'd528, xi, xq, ok);
    rstn = 1'b0;
    tick();
    tick();
    check_count++;
    if (bus.X !== 10'd512) $display("[TB] FAIL reset_x: got %0d expected 512", bus.X);
    else pass_count++;
    check_count++;
    if (bus.channel !== 3'b000) $display("[TB] FAIL reset_channel: got %b expected 000", bus.channel);
    else pass_count++;
    check_count++;
    if (bus.x_valid !== 1'b0) $display("[TB] FAIL reset_x_valid: got %b expected 0", bus.x_valid);
    else pass_count++;
    rstn = 1'b1;
    #1;
    check_count++;
    if (bus.audio_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", bus.audio_ready);
    else pass_count++;
  endtask

  task automatic test_zero_audio();
    logic [9:0] xi, xq;
    logic ok;
    do_reset();
    for (int n = 0; n < 3; n++) begin
      send_sample(10'd512, xi, xq, ok);
      check_count++;
      if (!ok || xi !== 10'd1023 || xq !== 10'd512)
        $display("[TB] FAIL zero_audio_%0d: got ok=%b I=%0d Q=%0d expected ok=1 I=1023 Q=512", n, ok, xi, xq);
      else pass_count++;
    end
    check_count++;
    if (dut.phase_q !== 16'd0) $display("[TB] FAIL zero_audio_phase: got %0d expected 0", dut.phase_q);
    else pass_count++;
  endtask

  task automatic test_deviation();
    logic [9:0] xi, xq;
    logic ok;
    logic all_ok = 1'b1;
    do_reset();
    for (int n = 1; n <= 64; n++) begin
      send_sample(10'd528, xi, xq, ok);
      if (!ok) all_ok = 1'b0;
      if (n == 1) begin
        check_count++;
        if (xi !== 10'd1023 || xq !== 10'd525)
          $display("[TB] FAIL dev_first: got I=%0d Q=%0d expected I=1023 Q=525", xi, xq);
        else pass_count++;
      end
      if (n == 2) begin
        check_count++;
        if (xi !== 10'd1022 || xq !== 10'd537)
          $display("[TB] FAIL dev_second: got I=%0d Q=%0d expected I=1022 Q=537", xi, xq);
        else pass_count++;
      end
      if (n == 64) begin
        check_count++;
        if (xi !== 10'd512 || xq !== 10'd1023)
          $display("[TB] FAIL dev_64th: got I=%0d Q=%0d expected I=512 Q=1023", xi, xq);
        else pass_count++;
      end
    end
    check_count++;
    if (all_ok !== 1'b1) $display("[TB] FAIL dev_handshake: got %b expected 1", all_ok);
    else pass_count++;
  endtask

  task automatic test_wrap();
    logic [9:0] xi, xq;
    logic ok;
    logic in_range = 1'b1;
    logic all_ok   = 1'b1;
    do_reset();
    for (int n = 1; n <= 9; n++) begin
      send_sample(10'd1023, xi, xq, ok);
      if (!ok) all_ok = 1'b0;
      if (xi < 10'd1 || xq < 10'd1) in_range = 1'b0;
      if (n == 1 || n == 9) begin
        check_count++;
        if (xi !== 10'd882 || xq !== 10'd864)
          $display("[TB] FAIL wrap_sample_%0d: got I=%0d Q=%0d expected I=882 Q=864", n, xi, xq);
        else pass_count++;
      end
      if (n == 8) begin
        check_count++;
        if (xi !== 10'd1023 || xq !== 10'd499)
          $display("[TB] FAIL wrap_sample_8: got I=%0d Q=%0d expected I=1023 Q=499", xi, xq);
        else pass_count++;
      end
    end
    check_count++;
    if (in_range !== 1'b1 || all_ok !== 1'b1)
      $display("[TB] FAIL wrap_range: got range=%b ok=%b expected 1 1", in_range, all_ok);
    else pass_count++;
    check_count++;
    if (dut.phase_q !== 16'd8048) $display("[TB] FAIL wrap_phase: got %0d expected 8048", dut.phase_q);
    else pass_count++;
  endtask

  task automatic test_enable_stall();
    logic xv_low    = 1'b1;
    logic rdy_low   = 1'b1;
    logic x_held    = 1'b1;
    int   i_seen    = 0;
    do_reset();
    bus.audio       = 10'd512;
    bus.audio_valid = 1'b1;
    tick();
    bus.audio_valid = 1'b0;
    tick();
    if (bus.x_valid === 1'b1 && bus.channel === 3'b110) i_seen++;
    en = 1'b0;
    #1;
    if (bus.x_valid !== 1'b0) xv_low = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus.x_valid !== 1'b0) xv_low = 1'b0;
      if (bus.audio_ready !== 1'b0) rdy_low = 1'b0;
      if (bus.X !== 10'd1023) x_held = 1'b0;
    end
    check_count++;
    if (xv_low !== 1'b1) $display("[TB] FAIL stall_x_valid: got %b expected 1 (low throughout)", xv_low);
    else pass_count++;
    check_count++;
    if (rdy_low !== 1'b1 || x_held !== 1'b1)
      $display("[TB] FAIL stall_hold: got ready_low=%b x_held=%b expected 1 1", rdy_low, x_held);
    else pass_count++;
    en = 1'b1;
    #1;
    check_count++;
    if (bus.x_valid !== 1'b1 || bus.channel !== 3'b110 || bus.X !== 10'd1023)
      $display("[TB] FAIL stall_resume_i: got v=%b ch=%b X=%0d expected 1 110 1023", bus.x_valid, bus.channel, bus.X);
    else pass_count++;
    tick();
    check_count++;
    if (bus.x_valid !== 1'b1 || bus.channel !== 3'b100 || bus.X !== 10'd512)
      $display("[TB] FAIL stall_resume_q: got v=%b ch=%b X=%0d expected 1 100 512", bus.x_valid, bus.channel, bus.X);
    else pass_count++;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.x_valid === 1'b1) i_seen++;
    end
    check_count++;
    if (i_seen !== 1) $display("[TB] FAIL stall_no_dup: got %0d extra+first I cycles expected 1", i_seen);
    else pass_count++;
  endtask

  task automatic test_reset_midflight();
    logic [9:0] xi, xq;
    logic ok;
    logic quiet = 1'b1;
    do_reset();
    send_sample(10'd528, xi, xq, ok);
    bus.audio       = 10'd528;
    bus.audio_valid = 1'b1;
    tick();
    bus.audio_valid = 1'b0;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus.x_valid !== 1'b0 || bus.channel !== 3'b000) quiet = 1'b0;
    end
    check_count++;
    if (quiet !== 1'b1 || bus.X !== 10'd512)
      $display("[TB] FAIL midflight_quiet: got quiet=%b X=%0d expected 1 512", quiet, bus.X);
    else pass_count++;
    send_sample(10'd528, xi, xq, ok);
    check_count++;
    if (!ok || xi !== 10'd1023 || xq !== 10'd525)
      $display("[TB] FAIL midflight_restart: got ok=%b I=%0d Q=%0d expected 1 1023 525", ok, xi, xq);
    else pass_count++;
  endtask

  task automatic test_back_to_back();
    logic [9:0] xi, xq;
    logic ok;
    do_reset();
    send_sample(10'd512, xi, xq, ok);
    check_count++;
    if (bus.audio_ready !== 1'b1) $display("[TB] FAIL b2b_ready: got %b expected 1", bus.audio_ready);
    else pass_count++;
    send_sample(10'd528, xi, xq, ok);
    check_count++;
    if (!ok || xi !== 10'd1023 || xq !== 10'd525)
      $display("[TB] FAIL b2b_second: got ok=%b I=%0d Q=%0d expected 1 1023 525", ok, xi, xq);
    else pass_count++;
  endtask

  task automatic test_preemph();
    logic [9:0] xi, xq;
    logic ok;
    do_reset();
    send_sample(10'd512, xi, xq, ok);
    send_sample(10'd1023, xi, xq, ok);
    check_count++;
    if ($signed(dut.samp_q) !== 10'sd511) $display("[TB] FAIL preemph_step: got %0d expected 511", $signed(dut.samp_q));
    else pass_count++;
`ifdef FM_MOD_PREEMPH_EN
    send_sample(10'd1023, xi, xq, ok);
    check_count++;
    if ($signed(dut.samp_q) !== 10'sd511) $display("[TB] FAIL preemph_hold: got %0d expected 511", $signed(dut.samp_q));
    else pass_count++;
    send_sample(10'd600, xi, xq, ok);
    check_count++;
    if ($signed(dut.samp_q) !== -10'sd124) $display("[TB] FAIL preemph_down: got %0d expected -124", $signed(dut.samp_q));
    else pass_count++;
`else
    send_sample(10'd600, xi, xq, ok);
    check_count++;
    if ($signed(dut.samp_q) !== 10'sd88) $display("[TB] FAIL plain_audio: got %0d expected 88", $signed(dut.samp_q));
    else pass_count++;
`endif
  endtask

  initial begin
    rstn            = 1'b0;
    en              = 1'b1;
    bus.audio       = 10'd512;
    bus.audio_valid = 1'b0;
    test_reset();
    test_zero_audio();
    test_deviation();
    test_wrap();
    test_enable_stall();
    test_reset_midflight();
    test_back_to_back();
    test_preemph();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
